input_arbiter: RTL and testbench

INPUT_ARBITER -- requirements
Module: input_arbiter

---
 rtl/input_arbiter.sv | 67 ++++++
 tb/tb_input_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/input_arbiter.sv
// input_arbiter: two-source command arbiter with per-source pending slots, round-robin grant and drop accounting
module input_arbiter #(
    parameter int DEPTH = 8
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] p0_buttons,
    input  logic       p0_pulse,
    input  logic [3:0] p1_buttons,
    input  logic       p1_pulse,
    input  logic [3:0] fifo_count,
    output logic [3:0] fifo_vector,
    output logic       fifo_pulse,
    output logic       grant_id,
    output logic [7:0] drop_count,
    output logic [1:0] drop_src
);
    localparam logic [4:0] L_DEPTH = 5'(DEPTH);
    logic [1:0] r_valid;
    logic [3:0] r_data [2];
    logic       w_space;
    logic       w_grant;
    logic       w_sel;
    logic [1:0] w_q;
    logic [1:0] w_free;
    logic [1:0] w_cap;
    logic [1:0] w_drop;
    logic [1:0] w_clr;
    logic [8:0] w_sum;
    // grant selection, capture/drop decisions and saturating drop sum; in-flight write counts as occupied
    always_comb begin
        w_space = ({1'b0, fifo_count} + {4'b0, fifo_pulse}) < L_DEPTH;
        w_grant = enable & w_space & |r_valid;
        w_sel   = &r_valid ? ~grant_id : r_valid[1];
        w_clr   = w_grant ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
        w_q     = {enable & p1_pulse & |p1_buttons, enable & p0_pulse & |p0_buttons};
        w_free  = ~r_valid | w_clr;
        w_cap   = w_q & w_free;
        w_drop  = w_q & ~w_free;
        w_sum   = {1'b0, drop_count} + {8'b0, w_drop[0]} + {8'b0, w_drop[1]};
    end
    // slot, write-port and drop-statistics state
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_valid     <= 2'b00;
            r_data[0]   <= 4'b0;
            r_data[1]   <= 4'b0;
            fifo_pulse  <= 1'b0;
            fifo_vector <= 4'b0;
            grant_id    <= 1'b1;
            drop_count  <= 8'b0;
            drop_src    <= 2'b00;
        end else begin
            fifo_pulse <= w_grant;
            if (w_grant) begin
                fifo_vector <= w_sel ? r_data[1] : r_data[0];
                grant_id    <= w_sel;
            end
            r_valid <= (r_valid & ~w_clr) | w_cap;
            if (w_cap[0]) r_data[0] <= p0_buttons;
            if (w_cap[1]) r_data[1] <= p1_buttons;
            drop_count <= (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
            drop_src   <= drop_src | w_drop;
        end
    end
endmodule

// File: tb/tb_input_arbiter.sv
// tb_input_arbiter: directed stimulus with a cycle-level behavioural model and literal spot checks
module tb_input_arbiter;
    logic       sys_clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] p0_buttons = 4'b0;
    logic       p0_pulse = 1'b0;
    logic [3:0] p1_buttons = 4'b0;
    logic       p1_pulse = 1'b0;
    logic [3:0] fifo_count = 4'd0;
    logic [3:0] fifo_vector;
    logic       fifo_pulse;
    logic       grant_id;
    logic [7:0] drop_count;
    logic [1:0] drop_src;
    int checks = 0;
    int errors = 0;
    input_arbiter #(.DEPTH(8)) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable),
        .p0_buttons(p0_buttons), .p0_pulse(p0_pulse),
        .p1_buttons(p1_buttons), .p1_pulse(p1_pulse),
        .fifo_count(fifo_count), .fifo_vector(fifo_vector), .fifo_pulse(fifo_pulse),
        .grant_id(grant_id), .drop_count(drop_count), .drop_src(drop_src)
    );
    always #5 sys_clock = ~sys_clock;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask
    // model state: pending command per source, last write, drop statistics
    bit       m_live = 0;
    bit       m_has [2];
    int       m_cmd [2];
    bit       m_wr;
    int       m_vec;
    int       m_last;
    int       m_drops;
    bit [1:0] m_src;
    always @(posedge sys_clock) begin
        int pick;
        bit pl [2];
        int bt [2];
        pl[0] = p0_pulse; pl[1] = p1_pulse;
        bt[0] = int'(p0_buttons); bt[1] = int'(p1_buttons);
        if (reset) begin
            m_live = 1; m_has[0] = 0; m_has[1] = 0; m_cmd[0] = 0; m_cmd[1] = 0;
            m_wr = 0; m_vec = 0; m_last = 1; m_drops = 0; m_src = 0;
        end else if (!enable) begin
            m_wr = 0;
        end else begin
            pick = -1;
            if (int'(fifo_count) + int'(m_wr) < 8) begin
                if (m_has[0] && m_has[1]) pick = 1 - m_last;
                else if (m_has[0]) pick = 0;
                else if (m_has[1]) pick = 1;
            end
            m_wr = (pick >= 0);
            if (pick >= 0) begin
                m_vec = m_cmd[pick];
                m_last = pick;
                m_has[pick] = 0;
            end
            for (int n = 0; n < 2; n++) begin
                if (pl[n] && bt[n] != 0) begin
                    if (m_has[n]) begin
                        m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
                        m_src[n] = 1'b1;
                    end else begin
                        m_has[n] = 1;
                        m_cmd[n] = bt[n];
                    end
                end
            end
        end
    end
    // every cycle after the first reset the DUT outputs must equal the model
    always @(negedge sys_clock) begin
        if (m_live) begin
            chk("m_pulse", {7'b0, fifo_pulse}, {7'b0, m_wr});
            chk("m_vector", {4'b0, fifo_vector}, 8'(m_vec));
            chk("m_grant", {7'b0, grant_id}, 8'(m_last));
            chk("m_drops", drop_count, 8'(m_drops));
            chk("m_src", {6'b0, drop_src}, {6'b0, m_src});
        end
    end
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge sys_clock);
    endtask
    task automatic pulses(input logic a, input logic [3:0] av, input logic b, input logic [3:0] bv);
        p0_pulse = a; p0_buttons = av; p1_pulse = b; p1_buttons = bv;
    endtask
    initial begin
        cyc(2);
        reset = 1'b0;
        chk("rst_pulse", {7'b0, fifo_pulse}, 8'd0);
        chk("rst_grant", {7'b0, grant_id}, 8'd1);
        chk("rst_drops", drop_count, 8'd0);
        // single p0 command, two-cycle latency
        pulses(1, 4'b0101, 0, 4'b0);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        chk("lat_early", {7'b0, fifo_pulse}, 8'd0);
        cyc();
        chk("lat_pulse", {7'b0, fifo_pulse}, 8'd1);
        chk("lat_vec", {4'b0, fifo_vector}, 8'b0101);
        chk("lat_gid", {7'b0, grant_id}, 8'd0);
        cyc();
        chk("one_shot", {7'b0, fifo_pulse}, 8'd0);
        chk("vec_hold", {4'b0, fifo_vector}, 8'b0101);
        // simultaneous pulses: after reset p0 would win a tie; here round-robin after p0 picks p0 for the lone... both served back to back
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        pulses(1, 4'b0001, 1, 4'b0010);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        cyc();
        chk("tie_first", {4'b0, fifo_vector}, 8'b0001);
        chk("tie_gid0", {7'b0, grant_id}, 8'd0);
        cyc();
        chk("tie_second", {4'b0, fifo_vector}, 8'b0010);
        chk("tie_gid1", {7'b0, grant_id}, 8'd1);
        chk("tie_pulse", {7'b0, fifo_pulse}, 8'd1);
        cyc();
        // full FIFO: hold then drop
        fifo_count = 4'd8;
        pulses(1, 4'b0011, 0, 4'b0);
        cyc();
        pulses(1, 4'b0100, 0, 4'b0);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        chk("full_drop", drop_count, 8'd1);
        chk("full_src", {6'b0, drop_src}, 8'b01);
        cyc();
        chk("full_nowr", {7'b0, fifo_pulse}, 8'd0);
        fifo_count = 4'd7;
        cyc();
        chk("full_wr", {7'b0, fifo_pulse}, 8'd1);
        chk("full_vec", {4'b0, fifo_vector}, 8'b0011);
        // one free entry, both slots valid
        fifo_count = 4'd8;
        pulses(1, 4'b0110, 1, 4'b1001);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        cyc();
        fifo_count = 4'd7;
        cyc();
        chk("one_wr", {7'b0, fifo_pulse}, 8'd1);
        chk("one_vec", {4'b0, fifo_vector}, 8'b1001);
        cyc();
        chk("one_stall", {7'b0, fifo_pulse}, 8'd0);
        fifo_count = 4'd0;
        cyc();
        chk("one_rest", {4'b0, fifo_vector}, 8'b0110);
        cyc();
        // zero vector ignored
        pulses(0, 4'b0, 1, 4'b0000);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        cyc();
        chk("zero_nowr", {7'b0, fifo_pulse}, 8'd0);
        chk("zero_nodrop", drop_count, 8'd1);
        // enable low freezes capture and grant
        enable = 1'b0;
        pulses(1, 4'b0111, 0, 4'b0);
        cyc();
        pulses(0, 4'b0, 0, 4'b0);
        cyc();
        chk("dis_nocap", {7'b0, fifo_pulse}, 8'd0);
        enable = 1'b1;
        pulses(1, 4'b0111, 0, 4'b0);
        cyc();
        enable = 1'b0;
        pulses(0, 4'b0, 0, 4'b0);
        cyc(3);
        chk("dis_hold", {7'b0, fifo_pulse}, 8'd0);
        enable = 1'b1;
        cyc();
        chk("dis_resume", {4'b0, fifo_vector}, 8'b0111);
        chk("dis_pulse", {7'b0, fifo_pulse}, 8'd1);
        // dual drop then saturation
        fifo_count = 4'd8;
        pulses(1, 4'b1111, 1, 4'b1000);
        cyc();
        cyc();
        chk("dual_drop", drop_count, 8'd3);
        chk("dual_src", {6'b0, drop_src}, 8'b11);
        pulses(1, 4'b1111, 0, 4'b0);
        cyc(300);
        pulses(0, 4'b0, 0, 4'b0);
        chk("sat", drop_count, 8'd255);
        cyc();
        chk("sat_hold", drop_count, 8'd255);
        // reset with both slots pending
        reset = 1'b1;
        fifo_count = 4'd0;
        cyc();
        reset = 1'b0;
        chk("rr_vec", {4'b0, fifo_vector}, 8'd0);
        chk("rr_gid", {7'b0, grant_id}, 8'd1);
        chk("rr_drops", drop_count, 8'd0);
        chk("rr_src", {6'b0, drop_src}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_nowr", {7'b0, fifo_pulse}, 8'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
